// File: rtl/bus_serial_bridge.sv
// CPU parallel bus to narrow pin-bus bridge: serial address/data/command beats, waited reads.
// Define BSB_TIMEOUT_EN to abort reads whose wait run exceeds TIMEOUT cycles.
module bus_serial_bridge #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int LW      = 8,
   parameter int TIMEOUT = 15
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   output logic          rsp_err,
   output logic [LW-1:0] pin_a,
   output logic [LW-1:0] pin_d_out,
   output logic [LW-1:0] pin_d_oe,
   input  logic [LW-1:0] pin_d_in,
   output logic          pin_strobe,
   input  logic          pin_wait
);

   localparam int AB = AW / LW;
   localparam int DB = DW / LW;
   localparam int NB = (AB > DB) ? AB : DB;
   localparam int KW = (NB > 1) ? $clog2(NB) : 1;

   localparam logic [KW-1:0] A_LAST = KW'(NB - 1);
   localparam logic [KW-1:0] D_LAST = KW'(DB - 1);
   localparam logic [LW-1:0] CMD_RD = LW'(2);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ADDR = 3'd1;
   localparam logic [2:0] S_CMD  = 3'd2;
   localparam logic [2:0] S_READ = 3'd3;
   localparam logic [2:0] S_RESP = 3'd4;

   if ((AW % LW) != 0 || (DW % LW) != 0 || LW < 2 || TIMEOUT < 1) begin : g_bad_param
      $error("bus_serial_bridge: illegal parameter combination");
   end

   logic [2:0]    state;
   logic [KW-1:0] beat;
   logic          we;
   logic [AW-1:0] addr_sh;
   logic [DW-1:0] wdata_sh;
   logic [DW-1:0] rd_acc;
   logic [DW-1:0] rd_next;

`ifdef BSB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT);
   logic [TW-1:0] wcnt;
`endif

   assign req_ready = rst_n && (state == S_IDLE);

   // Lanes arrive LSB-first, so each capture enters at the top and shifts down.
   assign rd_next = (rd_acc >> LW) | (DW'(pin_d_in) << (DW - LW));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         beat       <= '0;
         we         <= 1'b0;
         addr_sh    <= '0;
         wdata_sh   <= '0;
         rd_acc     <= '0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
         rsp_err    <= 1'b0;
         pin_a      <= '0;
         pin_d_out  <= '0;
         pin_d_oe   <= '0;
         pin_strobe <= 1'b0;
`ifdef BSB_TIMEOUT_EN
         wcnt       <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  we         <= req_we;
                  addr_sh    <= req_addr >> LW;
                  wdata_sh   <= req_wdata >> LW;
                  rd_acc     <= '0;
                  beat       <= '0;
                  pin_a      <= req_addr[LW-1:0];
                  pin_d_out  <= req_we ? req_wdata[LW-1:0] : '0;
                  pin_d_oe   <= {LW{req_we}};
                  pin_strobe <= 1'b1;
                  state      <= S_ADDR;
               end
            end
            S_ADDR: begin
               pin_strobe <= 1'b0;
               if (beat == A_LAST) begin
                  pin_a     <= CMD_RD | LW'(we);
                  pin_d_out <= '0;
                  pin_d_oe  <= '0;
                  state     <= S_CMD;
               end else begin
                  beat      <= beat + KW'(1);
                  pin_a     <= addr_sh[LW-1:0];
                  addr_sh   <= addr_sh >> LW;
                  pin_d_out <= we ? wdata_sh[LW-1:0] : '0;
                  wdata_sh  <= wdata_sh >> LW;
               end
            end
            S_CMD: begin
               pin_a <= '0;
               beat  <= '0;
`ifdef BSB_TIMEOUT_EN
               wcnt  <= '0;
`endif
               if (we) begin
                  rsp_valid <= 1'b1;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
                  state     <= S_RESP;
               end else begin
                  state <= S_READ;
               end
            end
            S_READ: begin
               if (!pin_wait) begin
                  rd_acc <= rd_next;
`ifdef BSB_TIMEOUT_EN
                  wcnt   <= '0;
`endif
                  if (beat == D_LAST) begin
                     rsp_valid <= 1'b1;
                     rsp_rdata <= rd_next;
                     rsp_err   <= 1'b0;
                     state     <= S_RESP;
                  end else begin
                     beat <= beat + KW'(1);
                  end
`ifdef BSB_TIMEOUT_EN
               end else if (wcnt == T_MAX) begin
                  rsp_valid <= 1'b1;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b1;
                  state     <= S_RESP;
               end else begin
                  wcnt <= wcnt + TW'(1);
`endif
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_serial_bridge.sv
// Bench for bus_serial_bridge: per-cycle model comparison plus literal pins.
// Timeout expectations follow BSB_TIMEOUT_EN.
module tb_bus_serial_bridge;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 8;
   localparam int AB = AW / LW;
   localparam int DB = DW / LW;
   localparam int NB = (AB > DB) ? AB : DB;
   localparam int TO = 15;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic          req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0, pin_wait = 1'b0;
   logic [31:0]   req_addr = '0, req_wdata = '0;
   logic [7:0]    pin_d_in = '0;
   logic          req_ready, rsp_valid, rsp_err, pin_strobe;
   logic [31:0]   rsp_rdata;
   logic [7:0]    pin_a, pin_d_out, pin_d_oe;

   bus_serial_bridge #(.AW(AW), .DW(DW), .LW(LW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .pin_a(pin_a), .pin_d_out(pin_d_out), .pin_d_oe(pin_d_oe),
      .pin_d_in(pin_d_in), .pin_strobe(pin_strobe), .pin_wait(pin_wait)
   );

   logic          p_req_valid = 1'b0, p_req_we = 1'b0, p_rsp_ready = 1'b0, p_pin_wait = 1'b0;
   logic [15:0]   p_req_addr = '0;
   logic [31:0]   p_req_wdata = '0;
   logic [3:0]    p_pin_d_in = '0;
   logic          p_req_ready, p_rsp_valid, p_rsp_err, p_pin_strobe;
   logic [31:0]   p_rsp_rdata;
   logic [3:0]    p_pin_a, p_pin_d_out, p_pin_d_oe;

   bus_serial_bridge #(.AW(16), .DW(32), .LW(4), .TIMEOUT(TO)) u_p (
      .clk(clk), .rst_n(rst_n),
      .req_valid(p_req_valid), .req_ready(p_req_ready), .req_we(p_req_we),
      .req_addr(p_req_addr), .req_wdata(p_req_wdata),
      .rsp_valid(p_rsp_valid), .rsp_ready(p_rsp_ready),
      .rsp_rdata(p_rsp_rdata), .rsp_err(p_rsp_err),
      .pin_a(p_pin_a), .pin_d_out(p_pin_d_out), .pin_d_oe(p_pin_d_oe),
      .pin_d_in(p_pin_d_in), .pin_strobe(p_pin_strobe), .pin_wait(p_pin_wait)
   );

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model expectations for the current clock interval
   logic        e_on = 1'b0;
   logic [7:0]  e_a = '0, e_d = '0, e_oe = '0;
   logic        e_s = 1'b0, e_rv = 1'b0, e_err = 1'b0, e_rr = 1'b0;
   logic [31:0] e_rd = '0;

   always @(negedge clk) begin
      if (e_on) begin
         chk("pin_a", 64'(pin_a), 64'(e_a));
         chk("pin_d_out", 64'(pin_d_out), 64'(e_d));
         chk("pin_d_oe", 64'(pin_d_oe), 64'(e_oe));
         chk("pin_strobe", 64'(pin_strobe), 64'(e_s));
         chk("rsp_valid", 64'(rsp_valid), 64'(e_rv));
         chk("rsp_rdata", 64'(rsp_rdata), 64'(e_rd));
         chk("rsp_err", 64'(rsp_err), 64'(e_err));
         chk("req_ready", 64'(req_ready), 64'(e_rr));
      end
   end

   function automatic logic [7:0] lane(input logic [31:0] v, input int k);
      return (k < 4) ? v[k*8 +: 8] : 8'h00;
   endfunction

   task automatic set_idle(input logic rr);
      e_a = '0; e_d = '0; e_oe = '0; e_s = 1'b0;
      e_rv = 1'b0; e_rd = '0; e_err = 1'b0; e_rr = rr;
   endtask

   logic [7:0]  log_a [8];
   logic [31:0] first_rd;
   logic        first_err;

   task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input int wbeat, input int nwait,
                      input int hold, input int rst_at, output int lat);
      int beat, waits, cw, rcnt, off;
      logic abort, done;
      beat = 0; waits = 0; cw = 0; rcnt = 0; abort = 1'b0; done = 1'b0; lat = -1;
      req_valid = 1'b1; req_we = w; req_addr = a; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      for (off = 0; off < 400; off++) begin
         set_idle(1'b0);
         pin_wait = 1'b1; pin_d_in = 8'hEE; rsp_ready = 1'b0;
         if (off < 8) log_a[off] = pin_a;
         if (lat < 0 && rsp_valid) begin
            lat = off + 1; first_rd = rsp_rdata; first_err = rsp_err;
         end
         if (off < NB) begin
            e_a = (off < AB) ? lane(a, off) : 8'h00;
            e_d = (w && off < DB) ? lane(wd, off) : 8'h00;
            e_oe = w ? 8'hFF : 8'h00;
            e_s = (off == 0);
         end else if (off == NB) begin
            e_a = {6'b0, 1'b1, w};
         end else if (!w && beat < DB && !abort) begin
            if (beat == wbeat && waits < nwait) begin
               waits++;
`ifdef BSB_TIMEOUT_EN
               if (cw == TO) abort = 1'b1;
               else cw++;
`endif
            end else begin
               pin_wait = 1'b0; pin_d_in = lane(rd, beat); beat++; cw = 0;
            end
         end else begin
            e_rv = 1'b1; e_err = abort; e_rd = (w || abort) ? 32'h0 : rd;
            rsp_ready = (rcnt >= hold); rcnt++;
         end
         if (off == rst_at) rst_n = 1'b0;
         @(posedge clk); #1;
         if (off == rst_at) begin
            set_idle(1'b0); rsp_ready = 1'b1;
            @(posedge clk); #1;
            rst_n = 1'b1; done = 1'b1;
            break;
         end
         if (rsp_ready) begin
            done = 1'b1;
            break;
         end
      end
      chk("txn_done", 64'(done), 64'd1);
      set_idle(1'b1);
      pin_wait = 1'b0; pin_d_in = '0; rsp_ready = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end
   endtask

   logic [3:0]  pa_exp [9];
   logic [31:0] pr;
   int lat;

   initial begin
      repeat (3) @(posedge clk);
      #1;
      set_idle(1'b0);
      e_on = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      set_idle(1'b1);
      @(posedge clk); #1;

      txn(1'b1, 32'h11223344, 32'hAABBCCDD, 32'h0, -1, 0, 0, -1, lat);
      chk("wr_lat", 64'(lat), 64'd6);
      chk("wr_a0", 64'(log_a[0]), 64'h44);
      chk("wr_a1", 64'(log_a[1]), 64'h33);
      chk("wr_a2", 64'(log_a[2]), 64'h22);
      chk("wr_a3", 64'(log_a[3]), 64'h11);
      chk("wr_cmd", 64'(log_a[4]), 64'h03);

      txn(1'b0, 32'h4, 32'h0, 32'h12345678, -1, 0, 0, -1, lat);
      chk("rd_lat", 64'(lat), 64'd10);
      chk("rd_data", 64'(first_rd), 64'h12345678);
      chk("rd_cmd", 64'(log_a[4]), 64'h02);

      txn(1'b0, 32'h4, 32'h0, 32'h12345678, 1, 3, 0, -1, lat);
      chk("rdw_lat", 64'(lat), 64'd13);
      chk("rdw_data", 64'(first_rd), 64'h12345678);

      txn(1'b0, 32'h80, 32'h0, 32'hCAFEF00D, -1, 0, 5, -1, lat);
      txn(1'b1, 32'hDEADBEEF, 32'h01020304, 32'h0, -1, 0, 0, 2, lat);
      chk("rst_no_rsp", 64'(lat), 64'hFFFF_FFFF_FFFF_FFFF);

      txn(1'b0, 32'h100, 32'h0, 32'h0BADBEEF, 0, 120, 0, -1, lat);
`ifdef BSB_TIMEOUT_EN
      chk("to_lat", 64'(lat), 64'd22);
      chk("to_err", 64'(first_err), 64'd1);
      chk("to_data", 64'(first_rd), 64'h0);
`else
      chk("nto_lat", 64'(lat), 64'd130);
      chk("nto_data", 64'(first_rd), 64'h0BADBEEF);
`endif

      pa_exp = '{4'h3, 4'hC, 4'h5, 4'hA, 4'h0, 4'h0, 4'h0, 4'h0, 4'h2};
      pr = 32'h89ABCDEF;
      p_req_valid = 1'b1; p_req_we = 1'b0; p_req_addr = 16'hA5C3;
      @(posedge clk); #1;
      p_req_valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
         chk("p_pin_a", 64'(p_pin_a), 64'(pa_exp[i]));
         chk("p_pin_d_oe", 64'(p_pin_d_oe), 64'h0);
         @(posedge clk); #1;
      end
      for (int i = 0; i < 8; i++) begin
         p_pin_d_in = pr[i*4 +: 4];
         @(posedge clk); #1;
      end
      chk("p_rsp_valid", 64'(p_rsp_valid), 64'd1);
      chk("p_rsp_rdata", 64'(p_rsp_rdata), 64'h89ABCDEF);
      p_rsp_ready = 1'b1;
      @(posedge clk); #1;
      p_rsp_ready = 1'b0;
      chk("p_req_ready", 64'(p_req_ready), 64'd1);
      chk("p_rsp_done", 64'(p_rsp_valid), 64'd0);

      e_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
      $fatal(1, "watchdog");
   end

endmodule
